in_hand_shaking: RTL and testbench

Receive-side handshake block for a NoC router input port, mirroring the output-side handshake at the far end of the link. It accepts 64-bit packets from an upstream sender on a `si`/`ri` (send-in / ready-in) handshake and forwards them into the port's input FIFO via `write_en`. A 2-entry skid buffer decouples `ri` from the FIFO's `full` flag, so the link sustains one packet per cycle without a combinational path from `full` to `ri`. A wrapping counter reports accepted packets.

---
 rtl/in_hand_shaking.sv | 111 +++++++++++
 tb/tb_in_hand_shaking.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/in_hand_shaking.sv
// in_hand_shaking
//   Receive-side handshake for a NoC router input port. Packets arrive on a
//   si/ri handshake and are handed to the port's input FIFO through write_en.
//   A 2-entry skid buffer sits in between so that ri is a pure register decode
//   and never depends combinationally on the FIFO's full flag; the link still
//   sustains one packet per cycle while full stays low.
//
// Parameters
//   DEPTH  skid buffer entries (only 2 is supported)
//   CW     width of the accepted-packet counter
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   si          upstream has a valid packet on in_packet
//   in_packet   upstream packet data (64 bits)
//   ri          block can accept a packet this cycle
//   full        downstream input FIFO is full
//   write_en    write out_packet into the FIFO this cycle
//   out_packet  head of the skid buffer (0 when empty)
//   pkt_count   packets accepted, modulo 2^CW

`timescale 1ns/1ps

// One skid buffer slot: a plain load-enabled 64-bit register.
module in_hand_shaking_entry #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (we) q <= d;
  end
endmodule

module in_hand_shaking #(
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          si,
  input  logic [63:0]   in_packet,
  output logic          ri,
  input  logic          full,
  output logic          write_en,
  output logic [63:0]   out_packet,
  output logic [CW-1:0] pkt_count
);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNW = $clog2(DEPTH + 1);

  logic [CNW-1:0]              count, count_nxt;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [DEPTH-1:0][63:0]      entry;
  logic [DEPTH-1:0]            entry_we;
  logic                        acc;
  logic                        not_empty;

  // ri comes only from registers (and reset), so full never reaches it.
  assign not_empty  = (count != '0);
  assign ri         = !reset && (count < CNW'(DEPTH));
  assign acc        = si && ri;
  // No bypass: only stored packets can be written out.
  assign write_en   = !reset && not_empty && !full;
  assign out_packet = (!reset && not_empty) ? entry[rd_ptr] : '0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign entry_we[i] = acc && (wr_ptr == PW'(i));
    in_hand_shaking_entry #(.W(64)) u_entry (
      .clk  (clk),
      .reset(reset),
      .we   (entry_we[i]),
      .d    (in_packet),
      .q    (entry[i])
    );
  end

  // Occupancy: simultaneous accept and drain leaves it unchanged. Accept at
  // count==DEPTH cannot happen because ri is low there.
  always_comb begin
    count_nxt = count;
    case ({acc, write_en})
      2'b10:   count_nxt = count + CNW'(1);
      2'b01:   count_nxt = count - CNW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
    end else begin
      count <= count_nxt;
      if (acc) begin
        wr_ptr    <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        pkt_count <= pkt_count + CW'(1);
      end
      if (write_en)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    end
  end
endmodule

// File: tb/tb_in_hand_shaking.sv
`timescale 1ns/1ps

module tb_in_hand_shaking;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        si = 1'b0;
  logic [63:0] in_packet = '0;
  logic        ri;
  logic        full = 1'b0;
  logic        write_en;
  logic [63:0] out_packet;
  logic [15:0] pkt_count;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b1;

  // Reference model: an ordered list of stored packets and an accept tally.
  logic [63:0] mq[$];
  logic [15:0] mcnt = '0;

  in_hand_shaking #(.DEPTH(2), .CW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .si        (si),
    .in_packet (in_packet),
    .ri        (ri),
    .full      (full),
    .write_en  (write_en),
    .out_packet(out_packet),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare against the model, then advance the
  // model to what the next edge will produce.
  task automatic cyc(input logic s, input logic [63:0] p, input logic f);
    logic        m_ri, m_we;
    logic [63:0] m_out;
    @(negedge clk);
    si = s; in_packet = p; full = f;
    #1;
    m_ri  = (mq.size() < 2);
    m_we  = (mq.size() > 0) && !f;
    m_out = (mq.size() > 0) ? mq[0] : 64'd0;
    if (chk_on) begin
      chk_eq("model ri", ri, m_ri);
      chk_eq("model write_en", write_en, m_we);
      chk_eq("model out_packet", out_packet, m_out);
      chk_eq("model pkt_count", pkt_count, mcnt);
    end
    if (m_we) void'(mq.pop_front());
    if (s && m_ri) begin
      mq.push_back(p);
      mcnt = mcnt + 16'd1;
    end
  endtask

  // Assert reset mid-cycle, check outputs drop without an edge, release at
  // the next falling edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_eq("rst ri", ri, 0);
    chk_eq("rst write_en", write_en, 0);
    chk_eq("rst out_packet", out_packet, 0);
    chk_eq("rst pkt_count", pkt_count, 0);
    @(negedge clk);
    si = 1'b0; full = 1'b0;
    reset = 1'b0;
    mq.delete();
    mcnt = '0;
    #1;
    chk_eq("post-rst ri", ri, 1);
    chk_eq("post-rst write_en", write_en, 0);
    chk_eq("post-rst pkt_count", pkt_count, 0);
  endtask

  typedef struct {
    logic        si;
    logic [63:0] pkt;
    logic        full;
    logic        e_ri;
    logic        e_we;
    logic [63:0] e_out;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int we_seen;
    bit ri_drop;
    logic [63:0] exp_next;

    // single packet, then backpressure with A/B/C
    tbl[0] = '{1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b1, 1'b0, 64'h0, 16'd0};
    tbl[1] = '{1'b0, 64'h0,                   1'b0, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 16'd1};
    tbl[2] = '{1'b0, 64'h0,                   1'b0, 1'b1, 1'b0, 64'h0, 16'd1};
    tbl[3] = '{1'b1, 64'hA,                   1'b1, 1'b1, 1'b0, 64'h0, 16'd1};
    tbl[4] = '{1'b1, 64'hB,                   1'b1, 1'b1, 1'b0, 64'hA, 16'd2};
    tbl[5] = '{1'b1, 64'hC,                   1'b1, 1'b0, 1'b0, 64'hA, 16'd3};
    tbl[6] = '{1'b1, 64'hC,                   1'b0, 1'b0, 1'b1, 64'hA, 16'd3};
    tbl[7] = '{1'b1, 64'hC,                   1'b0, 1'b1, 1'b1, 64'hB, 16'd3};
    tbl[8] = '{1'b0, 64'h0,                   1'b0, 1'b1, 1'b1, 64'hC, 16'd4};
    tbl[9] = '{1'b0, 64'h0,                   1'b0, 1'b1, 1'b0, 64'h0, 16'd4};

    // power-on reset
    repeat (2) @(negedge clk);
    #1;
    chk_eq("por ri", ri, 0);
    chk_eq("por write_en", write_en, 0);
    chk_eq("por out_packet", out_packet, 0);
    chk_eq("por pkt_count", pkt_count, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) cyc(1'b0, 64'h0, 1'b0);

    // idle then mid-cycle reset (ri drops immediately)
    do_reset();

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].si, tbl[i].pkt, tbl[i].full);
      chk_eq($sformatf("tbl[%0d] ri", i), ri, tbl[i].e_ri);
      chk_eq($sformatf("tbl[%0d] write_en", i), write_en, tbl[i].e_we);
      chk_eq($sformatf("tbl[%0d] out_packet", i), out_packet, tbl[i].e_out);
      chk_eq($sformatf("tbl[%0d] pkt_count", i), pkt_count, tbl[i].e_cnt);
    end

    // streaming 0x01..0x10 at full rate
    do_reset();
    we_seen = 0; ri_drop = 1'b0; exp_next = 64'd1;
    for (int i = 0; i < 17; i++) begin
      cyc(i < 16, 64'(i + 1), 1'b0);
      if (!ri) ri_drop = 1'b1;
      if (write_en) begin
        chk_eq("stream order", out_packet, exp_next);
        exp_next++;
        we_seen++;
      end
    end
    chk_eq("stream write_en cycles", 64'(we_seen), 64'd16);
    chk_eq("stream ri dropped", 64'(ri_drop), 64'd0);
    chk_eq("stream pkt_count", pkt_count, 16'd16);

    // reset with two packets buffered: both are discarded
    do_reset();
    cyc(1'b1, 64'h11, 1'b1);
    cyc(1'b1, 64'h22, 1'b1);
    cyc(1'b0, 64'h0, 1'b1);
    chk_eq("full2 ri", ri, 0);
    chk_eq("full2 out_packet", out_packet, 64'h11);
    do_reset();
    cyc(1'b1, 64'h33, 1'b0);
    chk_eq("after-rst no write", write_en, 0);
    cyc(1'b0, 64'h0, 1'b0);
    chk_eq("first write is 0x33 we", write_en, 1);
    chk_eq("first write is 0x33", out_packet, 64'h33);
    chk_eq("after 0x33 pkt_count", pkt_count, 16'd1);
    cyc(1'b0, 64'h0, 1'b0);
    chk_eq("0x11/0x22 gone", write_en, 0);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
    repeat (3) cyc(1'b0, 64'h0, 1'b0);

    // counter wrap
    do_reset();
    chk_on = 1'b0;
    for (int i = 0; i < 65535; i++) cyc(1'b1, 64'(i), 1'b0);
    chk_on = 1'b1;
    cyc(1'b0, 64'h0, 1'b0);
    chk_eq("preload pkt_count", pkt_count, 16'hFFFF);
    cyc(1'b1, 64'hF00D, 1'b0);
    cyc(1'b0, 64'h0, 1'b0);
    chk_eq("wrap pkt_count", pkt_count, 16'h0000);
    chk_eq("wrap write value", out_packet, 64'hF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
